bist_session_sequencer: RTL and testbench
=========================================

Name: bist_session_sequencer

Overview:
Session controller that drives the full-adder BIST controller and consumes its results. On a start request it resets the BIST datapath, holds test mode for one LFSR sweep, and captures the MISR signature when the sweep completes. It repeats this for a set number of runs, compares each signature with the golden value, and reports pass/fail, a failure count and timeouts through a done pulse.

Parameters:
SIG_W, 4, MISR signature width
GOLDEN, 4'b0011, expected signature per run
INIT_CYCLES, 2, cycles bist_reset is held high per run (>=1)
TIMEOUT, 12, max RUN cycles waiting for complete before error (>=2)
RUNS, 2, runs per session (>=1)
CNT_W, 4, fail_count width

Ports:
clock  in  1  single clock, all logic posedge
reset  in  1  synchronous, active-low
start  in  1  session request, sampled in IDLE only
abort  in  1  cancel session, sampled in any non-IDLE state
complete  in  1  end-of-sweep flag from TPG
signature  in  SIG_W  MISR output
bist_reset  out  1  active-high reset to TPG/MISR
testmode  out  1  selects LFSR patterns into CUT
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at session end
pass  out  1  session result, held until next accepted start
fail_count  out  CNT_W  signature mismatches this session, saturating
timeout_err  out  1  sticky, set if any run timed out
fail_sig  out  SIG_W  see Optional Feature

Behaviour:
- Reset (reset==0 at a posedge): state=IDLE, all counters 0, all outputs 0. Reset wins over everything, including mid-session.
- States: IDLE, INIT, RUN, CHECK, DONE. All outputs are registered.
- IDLE: testmode=0, bist_reset=0. start==1 -> INIT. Accepting start clears pass, fail_count, timeout_err, fail_sig and run_idx.
- INIT: bist_reset=1, testmode=1 for exactly INIT_CYCLES cycles. Clears the run cycle counter, then -> RUN.
- RUN: bist_reset=0, testmode=1. The cycle counter increments each cycle.
  - complete==1: latch signature into sig_q, -> CHECK.
  - else if counter==TIMEOUT-1: timeout_err<=1, -> DONE (remaining runs skipped).
  - complete wins if it coincides with the last timeout cycle.
- CHECK (1 cycle): testmode=1.
  - sig_q!=GOLDEN: fail_count increments, saturating at all-ones.
  - run_idx==RUNS-1 -> DONE; else run_idx++ -> INIT.
- DONE (1 cycle): testmode=0, done=1, pass<=(no mismatch this session)&&!timeout_err (computed from next-state values). -> IDLE. done is never asserted elsewhere.
- abort==1 in INIT/RUN/CHECK/DONE: next state IDLE, testmode=0, bist_reset=0, no done pulse, pass=0. fail_count and timeout_err keep their current values. abort has priority over complete, timeout and CHECK transitions. abort in IDLE is ignored.
- start while busy is ignored. start and abort both high in IDLE: start is accepted (abort is ignored in IDLE).
- Latency with defaults and a fault-free CUT: start seen at edge 0 -> bist_reset high cycles 1-2, RUN from cycle 3. Session length = RUNS*(INIT_CYCLES+RUN cycles+1)+1.

Optional Feature:
BIST_SIG_LOG_EN
- Defined: fail_sig is loaded with sig_q on every mismatching CHECK (last failing signature wins) and cleared on start acceptance.
- Undefined: fail_sig is tied to 0; no extra register is inferred.

Test Plan:
- Pass path: defaults, complete asserted on the 8th RUN cycle each run, signature=4'b0011 -> two INIT/RUN/CHECK runs, done pulse, pass=1, fail_count=0, timeout_err=0, busy low the cycle after done.
- Single-run fault: signature=4'b0110 in run 1, 4'b0011 in run 2 -> pass=0, fail_count=1. With BIST_SIG_LOG_EN, fail_sig=4'b0110; without it, fail_sig=0.
- Timeout: complete never asserted -> after 12 RUN cycles timeout_err=1, done pulses, pass=0, and no second INIT occurs.
- Saturation: RUNS=20, CNT_W=4, every signature=4'b0000 -> fail_count stops at 15; done and pass=0.
- Abort/reset: abort in the 3rd RUN cycle -> IDLE next cycle, testmode=0, no done, pass=0. A new start then runs normally. In a separate session, reset=0 in CHECK -> all outputs 0 on the next edge.
- Busy-start and simultaneous complete/timeout: start pulses during RUN are ignored. complete=1 exactly on RUN cycle 12 -> CHECK (not timeout), timeout_err=0.

Source files
------------

// File: rtl/bist_session_sequencer.sv
// Session controller for the full-adder BIST: per run it resets TPG/MISR, sweeps, then checks the signature.
// Optional BIST_SIG_LOG_EN keeps the last failing signature on fail_sig; otherwise fail_sig is tied to 0.
module bist_session_sequencer #(
  parameter int SIG_W = 4,
  parameter logic [SIG_W-1:0] GOLDEN = SIG_W'(4'b0011),
  parameter int INIT_CYCLES = 2,
  parameter int TIMEOUT = 12,
  parameter int RUNS = 2,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             complete,
  input  logic [SIG_W-1:0] signature,
  output logic             bist_reset,
  output logic             testmode,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] fail_count,
  output logic             timeout_err,
  output logic [SIG_W-1:0] fail_sig
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int IC_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int RC_W = $clog2(TIMEOUT);
  localparam int RI_W = (RUNS > 1) ? $clog2(RUNS) : 1;

  localparam logic [IC_W-1:0] INIT_LAST = IC_W'(INIT_CYCLES - 1);
  localparam logic [RC_W-1:0] TO_LAST   = RC_W'(TIMEOUT - 1);
  localparam logic [RI_W-1:0] RUN_LAST  = RI_W'(RUNS - 1);

  logic [2:0]       state, state_nx;
  logic [IC_W-1:0]  init_cnt;
  logic [RC_W-1:0]  run_cnt;
  logic [RI_W-1:0]  run_idx;
  logic [SIG_W-1:0] sig_q;
  logic [CNT_W-1:0] fc_nx;
  logic             to_nx;
  logic             mismatch;
  logic             aborting;
  logic             accept;

  assign mismatch = (sig_q != GOLDEN);
  assign aborting = abort && (state != S_IDLE);
  assign accept   = (state == S_IDLE) && start;

  always_comb begin
    state_nx = state;
    fc_nx    = fail_count;
    to_nx    = timeout_err;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_INIT;
          fc_nx    = '0;
          to_nx    = 1'b0;
        end
      end
      S_INIT: begin
        if (init_cnt == INIT_LAST) state_nx = S_RUN;
      end
      S_RUN: begin
        // complete takes precedence over a timeout landing on the same cycle
        if (complete) begin
          state_nx = S_CHECK;
        end else if (run_cnt == TO_LAST) begin
          state_nx = S_DONE;
          to_nx    = 1'b1;
        end
      end
      S_CHECK: begin
        if (mismatch && (fail_count != {CNT_W{1'b1}})) fc_nx = fail_count + CNT_W'(1);
        state_nx = (run_idx == RUN_LAST) ? S_DONE : S_INIT;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (aborting) begin
      state_nx = S_IDLE;
      fc_nx    = fail_count;
      to_nx    = timeout_err;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= S_IDLE;
      init_cnt    <= '0;
      run_cnt     <= '0;
      run_idx     <= '0;
      sig_q       <= '0;
      fail_count  <= '0;
      timeout_err <= 1'b0;
      pass        <= 1'b0;
      bist_reset  <= 1'b0;
      testmode    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      fail_count  <= fc_nx;
      timeout_err <= to_nx;
      // outputs are registered decodes of the state being entered
      bist_reset  <= (state_nx == S_INIT);
      testmode    <= (state_nx == S_INIT) || (state_nx == S_RUN) || (state_nx == S_CHECK);
      busy        <= (state_nx != S_IDLE);
      done        <= (state_nx == S_DONE);
      init_cnt    <= ((state == S_INIT) && (state_nx == S_INIT)) ? init_cnt + IC_W'(1) : '0;
      run_cnt     <= (state == S_RUN) ? run_cnt + RC_W'(1) : '0;
      if (accept) begin
        run_idx <= '0;
        pass    <= 1'b0;
      end
      if ((state == S_RUN) && complete && !aborting) sig_q <= signature;
      if ((state == S_CHECK) && (state_nx == S_INIT)) run_idx <= run_idx + RI_W'(1);
      if (state_nx == S_DONE) pass <= (fc_nx == '0) && !to_nx;
      if (aborting) pass <= 1'b0;
    end
  end

`ifdef BIST_SIG_LOG_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      fail_sig <= '0;
    end else if (accept) begin
      fail_sig <= '0;
    end else if ((state == S_CHECK) && !aborting && mismatch) begin
      fail_sig <= sig_q;
    end
  end
`else
  assign fail_sig = '0;
`endif

endmodule

// File: tb/tb_bist_session_sequencer.sv
// Directed bench for bist_session_sequencer; a second instance with RUNS=20 covers fail_count saturation.
module tb_bist_session_sequencer;

  logic       clock = 1'b0;
  logic       reset, start, abort, complete;
  logic [3:0] signature;

  logic       bist_reset, testmode, busy, done, pass, timeout_err;
  logic [3:0] fail_count, fail_sig;
  logic       s_bist_reset, s_testmode, s_busy, s_done, s_pass, s_timeout_err;
  logic [3:0] s_fail_count, s_fail_sig;

  int checks = 0;
  int failures = 0;

`ifdef BIST_SIG_LOG_EN
  localparam logic [3:0] EXP_FSIG = 4'b0110;
`else
  localparam logic [3:0] EXP_FSIG = 4'b0000;
`endif

  always #5 clock = ~clock;

  bist_session_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .complete(complete),
    .signature(signature), .bist_reset(bist_reset), .testmode(testmode), .busy(busy),
    .done(done), .pass(pass), .fail_count(fail_count), .timeout_err(timeout_err),
    .fail_sig(fail_sig)
  );

  bist_session_sequencer #(.RUNS(20)) dut_sat (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .complete(complete),
    .signature(signature), .bist_reset(s_bist_reset), .testmode(s_testmode), .busy(s_busy),
    .done(s_done), .pass(s_pass), .fail_count(s_fail_count), .timeout_err(s_timeout_err),
    .fail_sig(s_fail_sig)
  );

  // {bist_reset, testmode, busy, done, pass, timeout_err}
  wire [5:0] vec = {bist_reset, testmode, busy, done, pass, timeout_err};

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Entered one cycle after start is accepted; returns with the DUT in CHECK.
  task automatic run_once(input int cpl_at, input logic [3:0] sig, input bit pulse_start);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (vec !== 6'b111000) begin failures++; $display("FAIL init_vec cyc=%0d got=%b exp=111000", i, vec); end
      step();
    end
    for (int c = 1; c < cpl_at; c++) begin
      checks++;
      if (vec !== 6'b011000) begin failures++; $display("FAIL run_vec cyc=%0d got=%b exp=011000", c, vec); end
      if (pulse_start && c == 2) start = 1'b1;
      step();
      start = 1'b0;
    end
    complete = 1'b1;
    signature = sig;
    step();
    complete = 1'b0;
    checks++;
    if (vec !== 6'b011000) begin failures++; $display("FAIL check_vec got=%b exp=011000", vec); end
  endtask

  task automatic begin_session();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; abort = 1'b0; complete = 1'b0; signature = 4'b0000;
    step(); step();
    start = 1'b0;
    checks++;
    if (vec !== 6'b000000) begin failures++; $display("FAIL reset_vec got=%b exp=000000", vec); end
    checks++;
    if ({fail_count, fail_sig, s_busy} !== 9'b0) begin
      failures++; $display("FAIL reset_cnt got fc=%h fs=%h sbusy=%b exp=0", fail_count, fail_sig, s_busy);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_pass_path();
    begin_session();
    run_once(8, 4'b0011, 1'b0);
    step();
    run_once(8, 4'b0011, 1'b0);
    step();
    checks++;
    if (vec !== 6'b001110) begin failures++; $display("FAIL pass_done_vec got=%b exp=001110", vec); end
    checks++;
    if (fail_count !== 4'd0) begin failures++; $display("FAIL pass_fc got=%0d exp=0", fail_count); end
    step();
    checks++;
    if (vec !== 6'b000010) begin failures++; $display("FAIL pass_idle_vec got=%b exp=000010", vec); end
  endtask

  task automatic test_fault();
    begin_session();
    checks++;
    if (pass !== 1'b0) begin failures++; $display("FAIL fault_pass_clr got=%b exp=0", pass); end
    run_once(8, 4'b0110, 1'b0);
    step();
    checks++;
    if (fail_count !== 4'd1) begin failures++; $display("FAIL fault_fc_mid got=%0d exp=1", fail_count); end
    run_once(5, 4'b0011, 1'b0);
    step();
    checks++;
    if (vec !== 6'b001100) begin failures++; $display("FAIL fault_done_vec got=%b exp=001100", vec); end
    checks++;
    if ({fail_count, fail_sig} !== {4'd1, EXP_FSIG}) begin
      failures++; $display("FAIL fault_fc_sig got fc=%0d fs=%b exp fc=1 fs=%b", fail_count, fail_sig, EXP_FSIG);
    end
    step();
    checks++;
    if (vec !== 6'b000000) begin failures++; $display("FAIL fault_idle_vec got=%b exp=000000", vec); end
  endtask

  task automatic test_timeout();
    begin_session();
    step(); step();
    for (int c = 1; c < 12; c++) begin
      checks++;
      if (vec !== 6'b011000) begin failures++; $display("FAIL to_run_vec cyc=%0d got=%b exp=011000", c, vec); end
      step();
    end
    step();
    checks++;
    if (vec !== 6'b001101) begin failures++; $display("FAIL to_done_vec got=%b exp=001101", vec); end
    step();
    checks++;
    if (vec !== 6'b000001) begin failures++; $display("FAIL to_idle_vec got=%b exp=000001", vec); end
    step();
    checks++;
    if (vec !== 6'b000001) begin failures++; $display("FAIL to_no_init got=%b exp=000001", vec); end
  endtask

  task automatic test_abort();
    begin_session();
    checks++;
    if (timeout_err !== 1'b0) begin failures++; $display("FAIL abort_to_clr got=%b exp=0", timeout_err); end
    step(); step(); step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (vec !== 6'b000000) begin failures++; $display("FAIL abort_vec got=%b exp=000000", vec); end
    step(); step();
    checks++;
    if (vec !== 6'b000000) begin failures++; $display("FAIL abort_no_done got=%b exp=000000", vec); end
    begin_session();
    run_once(8, 4'b0011, 1'b0);
    step();
    run_once(8, 4'b0011, 1'b0);
    step();
    checks++;
    if (vec !== 6'b001110) begin failures++; $display("FAIL abort_restart got=%b exp=001110", vec); end
    step();
  endtask

  task automatic test_busy_start_and_edge_complete();
    begin_session();
    run_once(12, 4'b0011, 1'b1);
    checks++;
    if (timeout_err !== 1'b0) begin failures++; $display("FAIL edge_cpl_to got=%b exp=0", timeout_err); end
    step();
    run_once(6, 4'b0011, 1'b1);
    step();
    checks++;
    if (vec !== 6'b001110) begin failures++; $display("FAIL busy_start_done got=%b exp=001110", vec); end
    step();
  endtask

  task automatic test_reset_in_check();
    begin_session();
    run_once(4, 4'b0110, 1'b0);
    step();
    run_once(4, 4'b0110, 1'b0);
    checks++;
    if (fail_count !== 4'd1) begin failures++; $display("FAIL rst_pre_fc got=%0d exp=1", fail_count); end
    reset = 1'b0;
    step();
    checks++;
    if (vec !== 6'b000000) begin failures++; $display("FAIL rst_check_vec got=%b exp=000000", vec); end
    checks++;
    if ({fail_count, fail_sig} !== 8'h00) begin
      failures++; $display("FAIL rst_check_cnt got fc=%0d fs=%b exp=0", fail_count, fail_sig);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_saturation();
    int n;
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    complete = 1'b1;
    signature = 4'b0000;
    begin_session();
    n = 1;
    while (!s_done && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n !== 81) begin failures++; $display("FAIL sat_len got=%0d exp=81", n); end
    checks++;
    if ({s_fail_count, s_pass, s_timeout_err} !== {4'd15, 1'b0, 1'b0}) begin
      failures++; $display("FAIL sat_result got fc=%0d pass=%b to=%b exp fc=15 pass=0 to=0", s_fail_count, s_pass, s_timeout_err);
    end
    complete = 1'b0;
    step();
    checks++;
    if (s_busy !== 1'b0) begin failures++; $display("FAIL sat_idle got=%b exp=0", s_busy); end
  endtask

  initial begin
    test_reset();
    test_pass_path();
    test_fault();
    test_timeout();
    test_abort();
    test_busy_start_and_edge_complete();
    test_reset_in_check();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
